ps2_key_tracker: RTL and testbench
==================================

Name: ps2_key_tracker

Overview:
- Upstream stage of the scancode-to-ASCII converter.
- Receives raw PS/2 keyboard frames and decodes the E0/F0 prefixes.
- Tracks Shift/Caps state and presents one clean make-code byte, the `uppercase` flag and handshake pulses.
- The converter consumes `scan_code` and `uppercase` combinationally.

Parameters:
- SYNC_STAGES, 3, synchronizer depth for `ps2_clk`/`ps2_data`; minimum 2.
- TIMEOUT_CYCLES, 50000, idle clk cycles mid-frame before the receiver aborts (1 ms at 50 MHz).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- ps2_clk  in  1  raw PS/2 clock (asynchronous)
- ps2_data  in  1  raw PS/2 data (asynchronous)
- scan_code  out  8  last accepted non-modifier make code
- scan_ext  out  1  `scan_code` was E0-prefixed
- key_valid  out  1  1-cycle pulse per non-modifier make, typematic repeats included
- key_new  out  1  1-cycle pulse, first make only (no repeat); coincident with `key_valid`
- key_down  out  1  key in `scan_code`/`scan_ext` currently held
- uppercase  out  1  (shift_l | shift_r) ^ caps_on
- caps_on  out  1  Caps Lock toggle state
- press_cnt  out  8  count of `key_new` pulses, wraps 255->0
- frame_err  out  1  1-cycle pulse on a bad or aborted frame

Behaviour:
- Reset: every output and internal register is 0. The decoder goes to S_IDLE and the bit counter to 0. Reset asserted mid-frame discards the partial frame.
- Sync: `ps2_clk` and `ps2_data` each pass through SYNC_STAGES flops. A falling edge is synced previous = 1 and synced current = 0. `ps2_data` is sampled in the same cycle.
- Frame format: 11 bits, LSB first: start = 0, d0..d7, odd parity (d + p has an odd count of 1s), stop = 1. The bit counter runs 0..10.
- Frame completion: cycle N is the cycle in which the stop-bit edge is detected.
  - Valid frame: internal rx_rdy/rx_byte are registered at end of N.
  - Invalid frame (start≠0, stop≠1, or parity fail): `frame_err` goes high in N+1 and the byte is dropped. Decoder state is unchanged.
- Timeout: the idle counter clears on every falling edge. If the bit counter ≠ 0 and the counter reaches TIMEOUT_CYCLES, the counter returns to 0 and `frame_err` pulses. A falling edge in the same cycle wins: no timeout, the bit is accepted.
- Decoder FSM: consumes rx_byte when rx_rdy. All outputs update in N+2.
  - S_IDLE:
    - E0 -> S_EXT.
    - F0 -> S_BRK.
    - 00, AA, E1, EE, FA, FE, FF are ignored; stay in S_IDLE.
    - Any other byte is make(code, ext = 0); stay in S_IDLE.
  - S_EXT:
    - F0 -> S_EXT_BRK.
    - E0 -> stay in S_EXT.
    - Any other byte is make(code, ext = 1) -> S_IDLE.
  - S_BRK: any byte is break(code, 0) -> S_IDLE.
  - S_EXT_BRK: any byte is break(code, 1) -> S_IDLE.
- Modifiers: 12 (L-shift), 59 (R-shift), 14 (Ctrl, either ext), 58 (Caps).
  - A modifier make never changes `scan_code`, `scan_ext`, `key_down`, `key_valid` or `press_cnt`.
  - make 12 / break 12 sets / clears shift_l.
  - make 59 / break 59 sets / clears shift_r.
  - make 58 toggles `caps_on` only when caps_held = 0, then sets caps_held. break 58 clears caps_held, so typematic Caps does not re-toggle.
  - `uppercase` is registered and updates in the same cycle as the flags.
- Non-modifier make(c, e):
  - Repeat is defined as key_down & scan_code == c & scan_ext == e.
  - `key_valid` = 1.
  - `key_new` = !repeat.
  - `scan_code` <= c, `scan_ext` <= e, `key_down` <= 1.
  - `press_cnt` += 1 when `key_new`.
- Non-modifier break(c, e): clears `key_down` only if it matches the held code; otherwise no output change.
- Pulses (`key_valid`, `key_new`, `frame_err`) are high for exactly one clk cycle.
- `scan_code`, `scan_ext` and `uppercase` are stable whenever `key_valid` = 1.

Test Plan:
- Frame 1C -> `key_valid` = `key_new` = 1 for one cycle, 2 cycles after the stop-bit edge. `scan_code` = 1C, `scan_ext` = 0, `key_down` = 1, `press_cnt` = 1, `uppercase` = 0.
- 1C, 1C, 1C, F0 1C -> three extra `key_valid` pulses with `key_new` = 0. `press_cnt` stays 1. `key_down` = 0 after F0 1C.
- 12, 1C, F0 1C, F0 12 -> `uppercase` = 1 from the 12 make until F0 12, then 0. No `key_valid` for 12. `press_cnt` = 1.
- 58, 58, F0 58, 58, F0 58 -> `caps_on` is 1 after the first 58, 0 after the fourth byte. `uppercase` follows. No `key_valid` on any byte.
- E0 75, then E0 F0 75 -> `scan_code` = 75, `scan_ext` = 1, `key_down` = 1, then `key_down` = 0. A non-ext F0 75 instead leaves `key_down` = 1.
- Error cases:
  - Frame 1C with parity flipped -> `frame_err` pulse, no `key_valid`.
  - 5 bits then idle > TIMEOUT_CYCLES -> `frame_err` pulse.
  - Following good frame 1C -> decoded normally.
  - `rst` asserted mid-frame -> all outputs 0.

Source files
------------

// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard front end: synchronises the raw PS/2 lines, receives 11-bit frames,
// decodes E0/F0 prefixes and tracks Shift/Caps, presenting one clean make code per key.
//
// state     | meaning
// S_IDLE    | no prefix pending
// S_EXT     | E0 seen, next byte is an extended make (or F0)
// S_BRK     | F0 seen, next byte is a break code
// S_EXT_BRK | E0 F0 seen, next byte is an extended break code
module ps2_key_tracker #(
  parameter int SYNC_STAGES    = 3,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       scan_ext,
  output logic       key_valid,
  output logic       key_new,
  output logic       key_down,
  output logic       uppercase,
  output logic       caps_on,
  output logic [7:0] press_cnt,
  output logic       frame_err
);

  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_EXT     = 2'd1;
  localparam logic [1:0] S_BRK     = 2'd2;
  localparam logic [1:0] S_EXT_BRK = 2'd3;

  logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
  logic                   clk_prev_q;
  logic                   ps2_fall, ps2_bit;

  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [9:0]        shift_q, shift_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              rx_rdy_q, rx_rdy_d;
  logic [7:0]        rx_byte_q, rx_byte_d;
  logic              frame_err_q, frame_err_d;
  logic              frame_ok;

  logic [1:0] state_q, state_d;
  logic [7:0] scan_code_q, scan_code_d;
  logic       scan_ext_q, scan_ext_d;
  logic       key_valid_q, key_valid_d;
  logic       key_new_q, key_new_d;
  logic       key_down_q, key_down_d;
  logic [7:0] press_cnt_q, press_cnt_d;
  logic       shift_l_q, shift_l_d;
  logic       shift_r_q, shift_r_d;
  logic       caps_on_q, caps_on_d;
  logic       caps_held_q, caps_held_d;
  logic       uppercase_q, uppercase_d;

  logic       do_make, do_break, ev_ext, is_mod, is_ignored, is_repeat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q  <= '0;
      data_sync_q <= '0;
      clk_prev_q  <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
      clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
    end
  end

  assign ps2_fall = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
  assign ps2_bit  = data_sync_q[SYNC_STAGES-1];

  // shift_q holds start, d0..d7, parity (start at bit 0); the stop bit is the live sample
  assign frame_ok = ~shift_q[0] & ps2_bit & (^shift_q[9:1]);

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    idle_d      = idle_q;
    rx_rdy_d    = 1'b0;
    rx_byte_d   = rx_byte_q;
    frame_err_d = 1'b0;
    if (ps2_fall) begin
      idle_d = '0;
      if (bit_cnt_q == 4'd10) begin
        bit_cnt_d = 4'd0;
        if (frame_ok) begin
          rx_rdy_d  = 1'b1;
          rx_byte_d = shift_q[8:1];
        end else begin
          frame_err_d = 1'b1;
        end
      end else begin
        shift_d   = {ps2_bit, shift_q[9:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
        idle_d      = '0;
        bit_cnt_d   = 4'd0;
        frame_err_d = 1'b1;
      end else begin
        idle_d = idle_q + IDLE_W'(1);
      end
    end else begin
      idle_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q   <= 4'd0;
      shift_q     <= '0;
      idle_q      <= '0;
      rx_rdy_q    <= 1'b0;
      rx_byte_q   <= 8'h00;
      frame_err_q <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      idle_q      <= idle_d;
      rx_rdy_q    <= rx_rdy_d;
      rx_byte_q   <= rx_byte_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    is_ignored = 1'b0;
    case (rx_byte_q)
      8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFE, 8'hFF: is_ignored = 1'b1;
      default: is_ignored = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    do_make  = 1'b0;
    do_break = 1'b0;
    ev_ext   = 1'b0;
    if (rx_rdy_q) begin
      case (state_q)
        S_IDLE: begin
          if (rx_byte_q == 8'hE0)      state_d = S_EXT;
          else if (rx_byte_q == 8'hF0) state_d = S_BRK;
          else if (!is_ignored)        do_make = 1'b1;
        end
        S_EXT: begin
          if (rx_byte_q == 8'hF0) begin
            state_d = S_EXT_BRK;
          end else if (rx_byte_q != 8'hE0) begin
            do_make = 1'b1;
            ev_ext  = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_BRK: begin
          do_break = 1'b1;
          state_d  = S_IDLE;
        end
        default: begin
          do_break = 1'b1;
          ev_ext   = 1'b1;
          state_d  = S_IDLE;
        end
      endcase
    end
  end

  // Ctrl counts as a modifier in both plain and extended form; shifts/caps only plain
  assign is_mod = (rx_byte_q == 8'h14) |
                  (~ev_ext & ((rx_byte_q == 8'h12) | (rx_byte_q == 8'h59) | (rx_byte_q == 8'h58)));
  assign is_repeat = key_down_q & (scan_code_q == rx_byte_q) & (scan_ext_q == ev_ext);

  always_comb begin
    scan_code_d = scan_code_q;
    scan_ext_d  = scan_ext_q;
    key_valid_d = 1'b0;
    key_new_d   = 1'b0;
    key_down_d  = key_down_q;
    press_cnt_d = press_cnt_q;
    shift_l_d   = shift_l_q;
    shift_r_d   = shift_r_q;
    caps_on_d   = caps_on_q;
    caps_held_d = caps_held_q;
    if (do_make && is_mod) begin
      if (!ev_ext && rx_byte_q == 8'h12) shift_l_d = 1'b1;
      if (!ev_ext && rx_byte_q == 8'h59) shift_r_d = 1'b1;
      if (!ev_ext && rx_byte_q == 8'h58) begin
        if (!caps_held_q) caps_on_d = ~caps_on_q;
        caps_held_d = 1'b1;
      end
    end else if (do_make) begin
      key_valid_d = 1'b1;
      key_new_d   = ~is_repeat;
      scan_code_d = rx_byte_q;
      scan_ext_d  = ev_ext;
      key_down_d  = 1'b1;
      if (!is_repeat) press_cnt_d = press_cnt_q + 8'd1;
    end else if (do_break && is_mod) begin
      if (!ev_ext && rx_byte_q == 8'h12) shift_l_d = 1'b0;
      if (!ev_ext && rx_byte_q == 8'h59) shift_r_d = 1'b0;
      if (!ev_ext && rx_byte_q == 8'h58) caps_held_d = 1'b0;
    end else if (do_break && is_repeat) begin
      key_down_d = 1'b0;
    end
    uppercase_d = (shift_l_d | shift_r_d) ^ caps_on_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      scan_code_q <= 8'h00;
      scan_ext_q  <= 1'b0;
      key_valid_q <= 1'b0;
      key_new_q   <= 1'b0;
      key_down_q  <= 1'b0;
      press_cnt_q <= 8'h00;
      shift_l_q   <= 1'b0;
      shift_r_q   <= 1'b0;
      caps_on_q   <= 1'b0;
      caps_held_q <= 1'b0;
      uppercase_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      scan_code_q <= scan_code_d;
      scan_ext_q  <= scan_ext_d;
      key_valid_q <= key_valid_d;
      key_new_q   <= key_new_d;
      key_down_q  <= key_down_d;
      press_cnt_q <= press_cnt_d;
      shift_l_q   <= shift_l_d;
      shift_r_q   <= shift_r_d;
      caps_on_q   <= caps_on_d;
      caps_held_q <= caps_held_d;
      uppercase_q <= uppercase_d;
    end
  end

  assign scan_code = scan_code_q;
  assign scan_ext  = scan_ext_q;
  assign key_valid = key_valid_q;
  assign key_new   = key_new_q;
  assign key_down  = key_down_q;
  assign uppercase = uppercase_q;
  assign caps_on   = caps_on_q;
  assign press_cnt = press_cnt_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Bench for ps2_key_tracker: bit-banged PS/2 frames, a keyboard-level reference
// model feeding an event scoreboard, and a monitor that checks every output pulse.
module tb_ps2_key_tracker;
  localparam int SYNC = 3;
  localparam int TMO  = 200;
  localparam int HALF = 6;

  logic       clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic [7:0] scan_code, press_cnt;
  logic       scan_ext, key_valid, key_new, key_down, uppercase, caps_on, frame_err;

  ps2_key_tracker #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .scan_code(scan_code), .scan_ext(scan_ext), .key_valid(key_valid), .key_new(key_new),
    .key_down(key_down), .uppercase(uppercase), .caps_on(caps_on), .press_cnt(press_cnt),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    bit         is_err;
    logic [7:0] code;
    bit         ext;
    bit         is_new;
    logic [7:0] cnt;
    bit         up;
    int         lat;
  } ev_t;
  ev_t exp_q[$];
  ev_t mon_e;

  int n_checks = 0, n_err = 0, last_stop = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // keyboard-level model: pending prefix flags, held key, modifier flags
  bit         m_pext, m_pbrk, m_held, m_ext, m_sl, m_sr, m_caps, m_caps_held;
  logic [7:0] m_code, m_cnt;

  function automatic bit m_up();
    return (m_sl | m_sr) ^ m_caps;
  endfunction

  task automatic model_reset();
    m_pext = 0; m_pbrk = 0; m_held = 0; m_ext = 0; m_sl = 0; m_sr = 0;
    m_caps = 0; m_caps_held = 0; m_code = 8'h00; m_cnt = 8'h00;
  endtask

  task automatic model_key(input logic [7:0] c, input bit e, input bit brk);
    ev_t ev;
    bit mod, rep;
    mod = (c == 8'h14) || (!e && (c == 8'h12 || c == 8'h59 || c == 8'h58));
    if (mod) begin
      if (!e && c == 8'h12) m_sl = !brk;
      if (!e && c == 8'h59) m_sr = !brk;
      if (!e && c == 8'h58) begin
        if (!brk && !m_caps_held) m_caps = !m_caps;
        m_caps_held = !brk;
      end
    end else begin
      rep = m_held && m_code == c && m_ext == e;
      if (brk) begin
        if (rep) m_held = 0;
      end else begin
        if (!rep) m_cnt = m_cnt + 8'd1;
        m_code = c; m_ext = e; m_held = 1;
        ev.is_err = 0; ev.code = c; ev.ext = e; ev.is_new = !rep;
        ev.cnt = m_cnt; ev.up = m_up(); ev.lat = SYNC + 2;
        exp_q.push_back(ev);
      end
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (m_pbrk) begin
      model_key(b, m_pext, 1);
      m_pbrk = 0; m_pext = 0;
    end else if (b == 8'hF0) begin
      m_pbrk = 1;
    end else if (b == 8'hE0) begin
      m_pext = 1;
    end else if (!m_pext && (b == 8'h00 || b == 8'hAA || b == 8'hE1 || b == 8'hEE ||
                             b == 8'hFA || b == 8'hFE || b == 8'hFF)) begin
      // ignored in idle
    end else begin
      model_key(b, m_pext, 0);
      m_pext = 0;
    end
  endtask

  task automatic push_err(input int lat);
    ev_t ev;
    ev.is_err = 1; ev.code = 8'h00; ev.ext = 0; ev.is_new = 0; ev.cnt = 8'h00; ev.up = 0;
    ev.lat = lat;
    exp_q.push_back(ev);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad, input int nbits);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk); ps2_data = fr[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == 10) last_stop = cyc;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    @(negedge clk); ps2_data = 1'b1;
    repeat (30) @(negedge clk);
  endtask

  task automatic check_state();
    chk("key_down",  32'(key_down),  32'(m_held));
    chk("caps_on",   32'(caps_on),   32'(m_caps));
    chk("uppercase", 32'(uppercase), 32'(m_up()));
    chk("scan_code", 32'(scan_code), 32'(m_code));
    chk("scan_ext",  32'(scan_ext),  32'(m_ext));
    chk("press_cnt", 32'(press_cnt), 32'(m_cnt));
  endtask

  task automatic send_byte(input logic [7:0] b);
    model_byte(b);
    send_frame(b, 0, 11);
    check_state();
  endtask

  task automatic send_bad(input logic [7:0] b);
    push_err(SYNC + 1);
    send_frame(b, 1, 11);
    check_state();
  endtask

  task automatic check_all_zero(input string nm);
    chk(nm, 32'({scan_code, scan_ext, key_valid, key_new, key_down, uppercase, caps_on,
                 press_cnt, frame_err}), 32'd0);
  endtask

  // monitor: every pulse must match the head of the scoreboard
  bit prev_kv = 0;
  always @(negedge clk) begin
    if (rst) begin
      prev_kv = 0;
    end else begin
      if (key_valid) chk("key_valid_width", 32'(prev_kv), 32'd0);
      if (key_new)   chk("key_new_with_valid", 32'(key_valid), 32'd1);
      if (key_valid || frame_err) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_event", 32'({key_valid, frame_err}), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("ev_kind", 32'(frame_err), 32'(mon_e.is_err));
          if (!mon_e.is_err) begin
            chk("ev_code",      32'(scan_code), 32'(mon_e.code));
            chk("ev_ext",       32'(scan_ext),  32'(mon_e.ext));
            chk("ev_new",       32'(key_new),   32'(mon_e.is_new));
            chk("ev_press_cnt", 32'(press_cnt), 32'(mon_e.cnt));
            chk("ev_uppercase", 32'(uppercase), 32'(mon_e.up));
            chk("ev_key_down",  32'(key_down),  32'd1);
          end
          if (mon_e.lat >= 0) chk("ev_latency", 32'(cyc - last_stop), 32'(mon_e.lat));
        end
      end
      prev_kv = key_valid;
    end
  end

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted, errors=%0d checks=%0d", n_err, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (4) @(negedge clk);
    check_all_zero("reset_outputs");
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check_state();

    send_byte(8'h1C);
    send_byte(8'h1C); send_byte(8'h1C); send_byte(8'h1C);
    send_byte(8'hF0); send_byte(8'h1C);

    send_byte(8'h12); send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h1C);
    send_byte(8'hF0); send_byte(8'h12);

    send_byte(8'h58); send_byte(8'h58); send_byte(8'hF0); send_byte(8'h58);
    send_byte(8'h58); send_byte(8'hF0); send_byte(8'h58);

    send_byte(8'hE0); send_byte(8'h75);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    send_byte(8'hE0); send_byte(8'h75);
    send_byte(8'hF0); send_byte(8'h75);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);

    send_bad(8'h1C);
    push_err(-1);
    send_frame(8'h1C, 0, 5);
    repeat (TMO + 60) @(negedge clk);
    check_state();
    send_byte(8'h1C);

    for (int k = 0; k < 150; k++) begin
      logic [7:0] b;
      case ($urandom_range(0, 19))
        0, 1, 2:  b = 8'h1C;
        3:        b = 8'h32;
        4:        b = 8'h75;
        5:        b = 8'h12;
        6:        b = 8'h59;
        7:        b = 8'h58;
        8:        b = 8'h14;
        9, 10, 11: b = 8'hF0;
        12, 13:   b = 8'hE0;
        14:       b = 8'h00;
        15:       b = 8'hAA;
        default:  b = 8'($urandom);
      endcase
      if ($urandom_range(0, 19) == 0) send_bad(b);
      else send_byte(b);
    end

    repeat (20) @(negedge clk);
    chk("queue_drained_pre_reset", 32'(exp_q.size()), 32'd0);
    send_frame(8'h32, 0, 5);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("midframe_reset_outputs");
    model_reset();
    exp_q.delete();
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check_state();
    send_byte(8'h1C);

    repeat (20) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
